clint_timer: RTL
================

Name: clint_timer

Overview:
- Core-local interruptor: the memory-mapped producer end of the machine timer interrupt (clint_mtip) that the CSR block consumes.
- Holds 64-bit mtime and mtimecmp, advances mtime from a clock prescaler, and drives clint_mtip level-high while mtime >= mtimecmp.
- Sits on the core's MMIO path behind the LSU / AXI address decode, answering one register request at a time with a registered response.

Parameters:
- TICK_DIV, 1, clk cycles per mtime increment (1..65535); 1 = increment every cycle.
- BASE_ADDR, 64'h0200_0000, CLINT region base; offsets below are relative to it.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- req_addr  input  64  byte address, must be 8-byte aligned
- req_wen  input  1  1 = write, 0 = read
- req_wdata  input  64  write data
- req_wstrb  input  8  byte enables for writes
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  output  64  read data; 0 for writes and errors
- rsp_err  output  1  unmapped or misaligned access
- clint_mtip  output  1  machine timer interrupt pending, level

Behaviour:
- Register map (offsets):
  - 0x4000 mtimecmp, RW
  - 0xBFF8 mtime, RW
  - 0x0000 msip, only with the optional feature
  - all others: rsp_err=1; writes ignored, rdata=0.
- Misaligned (req_addr[2:0]!=0): rsp_err=1, no side effect.
- Reset values:
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF
  - clint_mtip=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
- Handshake:
  - req_ready = ~rsp_valid | rsp_ready; at most one outstanding response.
  - Request accepted in cycle N → rsp_valid=1 in cycle N+1, held with stable rdata/err until rsp_ready.
  - Back-to-back accept allowed in the cycle the prior response is consumed.
- Read data is the register value sampled in the accept cycle, before that cycle's update.
- Writes are byte-merged per wstrb and take effect at the end of the accept cycle; wstrb=0 is a legal no-op write (rsp_err=0).
- Prescaler:
  - Counts 0..TICK_DIV-1; tick when count==TICK_DIV-1, then wraps to 0.
  - TICK_DIV=1: tick every cycle.
  - On tick, mtime <= mtime+1, wrapping 2^64-1 → 0 with no flag.
- Simultaneous events:
  - Software write to mtime in a tick cycle: the written value wins, no increment that cycle.
  - Prescaler is not reset by a mtime write.
- clint_mtip is registered: clint_mtip <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare, where *_next are the values being written this cycle.
  - mtip reflects a compare-changing write or tick one cycle later.
  - Clearing: write mtimecmp > mtime; mtip drops the cycle after.
- Reset mid-transaction: a pending response is dropped (rsp_valid=0 next cycle); all registers return to reset values.

Optional Feature:
- Macro: CLINT_MSIP_EN.
- Defined:
  - 32-bit msip register at offset 0x0000; only bit 0 is writable, other bits read 0.
  - Extra output port clint_msip (1 bit) = msip[0], registered; reset 0.
  - Reads at 0x0000 return {63'b0, msip[0]}.
- Not defined: offset 0x0000 decodes as unmapped (rsp_err=1), and there is no clint_msip port.

Decomposition:
- defines.v additions:
  - CLINT_BASE, CLINT_MTIMECMP_OFF, CLINT_MTIME_OFF, CLINT_MSIP_OFF
  - CLINT_ADDR_BUS width macro
  - reuse DATA_BUS / DATA_BUS_SIZE for 64-bit data.
- One sub-module: clint_prescaler (counter plus tick output, parameter TICK_DIV).
- Byte-merge and the compare stay inline.

Test Plan:
- Reset then idle 10 cycles, TICK_DIV=1 → read 0xBFF8 returns 10 (±handshake offset checked exactly); clint_mtip=0; read 0x4000 returns all-ones.
- TICK_DIV=4: write mtime=0, read after 16 cycles → 4; prescaler wrap verified at count 3.
- Write mtimecmp=20 with mtime=15 → clint_mtip rises exactly one cycle after mtime reaches 20; write mtimecmp=100 → clint_mtip falls the cycle after accept.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFF with mtimecmp all-ones → mtip=1; after one tick mtime=0 and mtip=0.
- Stall rsp_ready low 5 cycles after a read → req_ready=0, rsp_rdata stable; write with wstrb=8'h0F, wdata=64'h1111_2222_3333_4444 to mtimecmp=all-ones → readback 64'hFFFF_FFFF_3333_4444.
- Access 0x0008 and misaligned 0x4004 → rsp_err=1, rdata=0, registers unchanged; with CLINT_MSIP_EN, write 0x0000=3 → clint_msip=1, readback 1.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: bus widths, register offsets, address decode.
// The msip register is decoded only when CLINT_MSIP_EN is defined.
package clint_timer_pkg;

  localparam int DATA_BUS_SIZE  = 64;
  localparam int CLINT_ADDR_BUS = 64;

  typedef logic [DATA_BUS_SIZE-1:0]  data_bus_t;
  typedef logic [CLINT_ADDR_BUS-1:0] addr_bus_t;

  localparam addr_bus_t CLINT_BASE         = 64'h0000_0000_0200_0000;
  localparam addr_bus_t CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam addr_bus_t CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam addr_bus_t CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } clint_reg_e;

  // Misaligned addresses never select a register, so they fall out as errors.
  function automatic clint_reg_e clint_decode(input addr_bus_t addr, input addr_bus_t base);
    clint_reg_e sel;
    sel = REG_NONE;
    if (addr[2:0] == 3'b000) begin
      if (addr == base + CLINT_MTIMECMP_OFF) begin
        sel = REG_MTIMECMP;
      end else if (addr == base + CLINT_MTIME_OFF) begin
        sel = REG_MTIME;
      end
`ifdef CLINT_MSIP_EN
      else if (addr == base + CLINT_MSIP_OFF) begin
        sel = REG_MSIP;
      end
`endif
    end
    return sel;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Free-running divider: tick is high for one cycle out of every TICK_DIV.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [15:0] count_reg;

  assign tick = (count_reg == 16'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp registers, registered mtip, one-deep response slot.
// Optional msip register and clint_msip port when CLINT_MSIP_EN is defined.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter addr_bus_t   BASE_ADDR = CLINT_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        clint_mtip
`ifdef CLINT_MSIP_EN
  ,
  output logic        clint_msip
`endif
);

  data_bus_t  mtime_reg;
  data_bus_t  mtime_next;
  data_bus_t  mtimecmp_reg;
  data_bus_t  mtimecmp_next;
  data_bus_t  wmask;
  data_bus_t  rdata_next;
  logic       err_next;
  logic       tick;
  logic       accept;
  logic       wr;
  clint_reg_e sel;

  clint_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign wr        = accept & req_wen;
  assign sel       = clint_decode(req_addr, BASE_ADDR);
  assign err_next  = (sel == REG_NONE);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
    end
  endgenerate

`ifdef CLINT_MSIP_EN
  logic msip_next;

  always_comb begin
    msip_next = clint_msip;
    if (wr && sel == REG_MSIP && req_wstrb[0]) begin
      msip_next = req_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clint_msip <= 1'b0;
    end else begin
      clint_msip <= msip_next;
    end
  end
`endif

  // A software write to mtime overrides the tick increment for that cycle.
  always_comb begin
    mtime_next    = tick ? mtime_reg + 64'd1 : mtime_reg;
    mtimecmp_next = mtimecmp_reg;
    if (wr && sel == REG_MTIME && |req_wstrb) begin
      mtime_next = (mtime_reg & ~wmask) | (req_wdata & wmask);
    end
    if (wr && sel == REG_MTIMECMP) begin
      mtimecmp_next = (mtimecmp_reg & ~wmask) | (req_wdata & wmask);
    end
  end

  always_comb begin
    rdata_next = '0;
    if (!req_wen) begin
      case (sel)
        REG_MTIME:    rdata_next = mtime_reg;
        REG_MTIMECMP: rdata_next = mtimecmp_reg;
`ifdef CLINT_MSIP_EN
        REG_MSIP:     rdata_next = {63'b0, clint_msip};
`endif
        default:      rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= '1;
      clint_mtip   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      clint_mtip   <= (mtime_next >= mtimecmp_next);
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rdata_next;
        rsp_err   <= err_next;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
